funct_generator_reader: RTL
===========================

FUNCT_GENERATOR_READER -- requirements
Module: funct_generator_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 32: sample width; signed fixed point, 4 integer bits, range [3:4-DATA_WIDTH].
REQ-002 Parameter DIV_WIDTH, default 16: width of the sample-period divider.
REQ-003 Port clk, input, 1: single clock; all state is updated on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port enh, input, 1: block enable; low forces idle.
REQ-006 Port div_i, input, DIV_WIDTH: sample period minus one, in clk cycles.
REQ-007 Port fifo_empty_i, input, 1: FIFO empty flag.
REQ-008 Port fifo_data_i, input, signed [3:4-DATA_WIDTH]: FIFO read data, valid one cycle after fifo_rd_o.
REQ-009 Port fifo_rd_o, output, 1: FIFO read strobe, one cycle per sample.
REQ-010 Port data_o, output, signed [3:4-DATA_WIDTH]: current output sample.
REQ-011 Port valid_o, output, 1: data_o holds a new, unconsumed sample.
REQ-012 Port ready_i, input, 1: downstream accepts data_o when valid_o and ready_i are both high.
REQ-013 Port underrun_o, output, 1: sticky flag; a tick found the FIFO empty.
REQ-014 Port stall_o, output, 1: sticky flag; a tick occurred while valid_o was still pending.

Function
REQ-015 The tick counter shall count 0..div_i and pulse tick in the cycle where count equals div_i, then reload to 0; div_i=0 shall give a tick every cycle.
REQ-016 The counter shall sample div_i only on reload; a mid-period change takes effect from the next period.
REQ-017 The FSM shall have states IDLE, WAIT, CAPT and HOLD.
REQ-018 IDLE -> WAIT when enh=1; the counter starts from 0.
REQ-019 In WAIT, a tick with fifo_empty_i=0 shall assert fifo_rd_o combinationally in that same cycle, then go to CAPT.
REQ-020 In WAIT, a tick with fifo_empty_i=1 shall set underrun_o, leave fifo_rd_o low, and stay in WAIT; data_o holds its last value.
REQ-021 In CAPT, fifo_data_i shall be registered into data_o, valid_o shall go high on the following edge, and the FSM shall go to HOLD.
REQ-022 Latency: with a tick in cycle T, fifo_rd_o is high in T and data_o/valid_o are valid from T+2.
REQ-023 In HOLD, valid_o shall stay high and data_o stable until a cycle with ready_i=1, then valid_o falls and the FSM returns to WAIT.
REQ-024 A tick in CAPT or HOLD shall set stall_o, cause no FIFO read, and be dropped; the counter keeps running.
REQ-025 A tick in the same cycle as the HOLD handshake shall count as a stall, not as a read.
REQ-026 fifo_rd_o shall never be high while fifo_empty_i=1, and shall be high for at most one cycle per tick.
REQ-027 enh=0 in any state shall, on the next edge: go to IDLE, force valid_o=0 and data_o=0, clear the counter and both sticky flags, and discard any in-flight read.
REQ-028 The block shall perform no arithmetic on samples; data shall pass through bit-exact, sign preserved.

Reset
REQ-029 rst_n low shall immediately set the FSM to IDLE, the counter to 0, data_o to 0, and valid_o, underrun_o and stall_o to 0.
REQ-030 fifo_rd_o shall be 0 while rst_n is low.
REQ-031 Operation shall resume at the first rising edge after rst_n deasserts with enh high.

Structure
REQ-032 The FSM state enum and the default DATA_WIDTH/DIV_WIDTH constants shall live in shared package funct_generator_pkg.
REQ-033 The tick counter shall be a separate sub-module, funct_generator_tick (inputs clk, rst_n, clr, div; output tick).
REQ-034 All outputs except fifo_rd_o shall be registered.

Verification
REQ-035 Steady flow: div_i=3, FIFO holds 8 samples, ready_i=1 -> fifo_rd_o every 4th cycle; samples appear bit-exact in order, including 0x8000_0000 and 0x7FFF_FFFF.
REQ-036 Underrun: div_i=0, FIFO empty -> fifo_rd_o never high and underrun_o=1 after the first tick; a push then gives valid_o 2 cycles after the next tick.
REQ-037 Backpressure: div_i=1, ready_i=0 for 6 cycles -> data_o stable, valid_o held high, stall_o=1, exactly one FIFO read.
REQ-038 Disable mid-read: enh drops in the CAPT cycle -> next cycle valid_o=0, data_o=0, flags cleared; the captured sample never appears.
REQ-039 Async reset in HOLD: rst_n pulsed low between edges -> outputs zero immediately; after release the first sample arrives div_i+3 cycles after enh.
REQ-040 Divider change: div_i switched from 2 to 5 mid-period -> the current period completes at 3 cycles; subsequent periods are 6 cycles.

Source files
------------

// File: rtl/funct_generator_pkg.sv
// Shared definitions for the function-generator FIFO reader: FSM states and
// default widths.
package funct_generator_pkg;

  localparam int FG_DATA_WIDTH = 32;
  localparam int FG_DIV_WIDTH  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    CAPT = 2'd2,
    HOLD = 2'd3
  } fg_state_e;

endpackage

// File: rtl/funct_generator_tick.sv
// Sample-period tick generator: counts 0..div and pulses tick on the last count.
// The period length is captured only on clear or reload.
module funct_generator_tick
  import funct_generator_pkg::*;
#(
  parameter int DIV_WIDTH = FG_DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt_r;
  logic [DIV_WIDTH-1:0] div_r;

  assign tick = (cnt_r == div_r);

  // Period counter with divider latched at clear/reload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {DIV_WIDTH{1'b0}};
      div_r <= {DIV_WIDTH{1'b0}};
    end else if (clr || tick) begin
      cnt_r <= {DIV_WIDTH{1'b0}};
      div_r <= div;
    end else begin
      cnt_r <= cnt_r + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/funct_generator_reader.sv
// Reads one FIFO sample per period tick and presents it downstream with a
// valid/ready handshake; flags underruns and dropped (stalled) ticks.
module funct_generator_reader
  import funct_generator_pkg::*;
#(
  parameter int DATA_WIDTH = FG_DATA_WIDTH,
  parameter int DIV_WIDTH  = FG_DIV_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enh,
  input  logic [DIV_WIDTH-1:0]         div_i,
  input  logic                         fifo_empty_i,
  input  logic signed [3:4-DATA_WIDTH] fifo_data_i,
  output logic                         fifo_rd_o,
  output logic signed [3:4-DATA_WIDTH] data_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic                         underrun_o,
  output logic                         stall_o
);

  fg_state_e                    state_r;
  fg_state_e                    state_nxt_s;
  logic                         tick_s;
  logic                         clr_s;
  logic                         rd_s;
  logic signed [3:4-DATA_WIDTH] data_r;
  logic                         valid_r;
  logic                         underrun_r;
  logic                         stall_r;

  // Counter restarts from zero whenever the block is idle or being disabled
  assign clr_s = !enh || (state_r == IDLE);

  funct_generator_tick #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr_s),
    .div  (div_i),
    .tick (tick_s)
  );

  // Next-state and read-strobe decode
  always_comb begin
    state_nxt_s = state_r;
    rd_s        = 1'b0;
    if (!enh) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: state_nxt_s = WAIT;
        WAIT: begin
          if (tick_s && !fifo_empty_i) begin
            rd_s        = 1'b1;
            state_nxt_s = CAPT;
          end else begin
            state_nxt_s = WAIT;
          end
        end
        CAPT: state_nxt_s = HOLD;
        HOLD: begin
          if (ready_i) begin
            state_nxt_s = WAIT;
          end else begin
            state_nxt_s = HOLD;
          end
        end
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Output sample, handshake and sticky flags; disable wins over everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r     <= {DATA_WIDTH{1'b0}};
      valid_r    <= 1'b0;
      underrun_r <= 1'b0;
      stall_r    <= 1'b0;
    end else if (!enh) begin
      data_r     <= {DATA_WIDTH{1'b0}};
      valid_r    <= 1'b0;
      underrun_r <= 1'b0;
      stall_r    <= 1'b0;
    end else begin
      if (state_r == CAPT) begin
        data_r  <= fifo_data_i;
        valid_r <= 1'b1;
      end else if ((state_r == HOLD) && ready_i) begin
        valid_r <= 1'b0;
      end
      if ((state_r == WAIT) && tick_s && fifo_empty_i) begin
        underrun_r <= 1'b1;
      end
      // Includes the handshake cycle in HOLD: that tick is dropped, not read
      if (tick_s && ((state_r == CAPT) || (state_r == HOLD))) begin
        stall_r <= 1'b1;
      end
    end
  end

  assign fifo_rd_o  = rd_s;
  assign data_o     = data_r;
  assign valid_o    = valid_r;
  assign underrun_o = underrun_r;
  assign stall_o    = stall_r;

endmodule
